// File: rtl/lsq_ram_pkg.sv
// Shared types and address helpers for the partitioned, power-gated LSQ data RAM.
// Optional build macro used by this slice: PART_CLEAR_ON_WAKE_EN.
package lsq_ram_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'b00,
    WAKE = 2'b01,
    ON   = 2'b10
  } part_state_t;

  localparam int WAKE_CNT_W = 4;

  // The upper partsLog bits of an index-bit address select the partition.
  function automatic int unsigned part_sel(input int unsigned addr,
                                           input int unsigned index,
                                           input int unsigned partsLog);
    if (partsLog == 0) return 0;
    return addr >> (index - partsLog);
  endfunction

  function automatic int unsigned row_idx(input int unsigned addr,
                                          input int unsigned index,
                                          input int unsigned partsLog);
    return addr & ((32'd1 << (index - partsLog)) - 32'd1);
  endfunction

endpackage

// File: rtl/lsq_ram_partitioned_gated_part.sv
// One RAM partition: storage, OFF/WAKE/ON power FSM with wake counter, write qualification.
// With PART_CLEAR_ON_WAKE_EN defined, WAKE also zeroes the rows one per cycle.
module lsq_ram_part
  import lsq_ram_pkg::*;
#(
  parameter int NUM_RD_PORTS = 2,
  parameter int NUM_WR_PORTS = 2,
  parameter int ROWS         = 8,
  parameter int RW           = 3,
  parameter int WIDTH        = 64,
  parameter int WAKE_LAT     = 3
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   req_i,
  input  logic [NUM_RD_PORTS-1:0][RW-1:0]        rdRow_i,
  output logic [NUM_RD_PORTS-1:0][WIDTH-1:0]     rdData_o,
  input  logic [NUM_WR_PORTS-1:0]                wrEn_i,
  input  logic [NUM_WR_PORTS-1:0][RW-1:0]        wrRow_i,
  input  logic [NUM_WR_PORTS-1:0][WIDTH-1:0]     wrData_i,
  output logic [NUM_WR_PORTS-1:0]                wrDrop_o,
  output logic                                   ready_o,
  output part_state_t                            state_o
);

`ifdef PART_CLEAR_ON_WAKE_EN
  localparam int WAKE_CYC = (WAKE_LAT > ROWS) ? WAKE_LAT : ROWS;
  localparam int CLR_W    = $clog2(ROWS + 1);
`else
  localparam int WAKE_CYC = WAKE_LAT;
`endif
  localparam int CNT_W = (WAKE_CYC > (1 << WAKE_CNT_W)) ? $clog2(WAKE_CYC) : WAKE_CNT_W;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAKE_CYC - 1);

  part_state_t             state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    ready_q;
  logic [WIDTH-1:0]        mem_q [ROWS];
  logic [NUM_WR_PORTS-1:0] wrCommit;

`ifdef PART_CLEAR_ON_WAKE_EN
  logic [CLR_W-1:0] clrRow_q;
  logic             clrEn;

  assign clrEn = (state_q == WAKE) && req_i && (clrRow_q < CLR_W'(ROWS));
`endif

  assign state_o = state_q;
  assign ready_o = ready_q;

  always_comb begin
    wrCommit = '0;
    wrDrop_o = '0;
    for (int w = 0; w < NUM_WR_PORTS; w++) begin
      wrCommit[w] = wrEn_i[w] && (state_q == ON) && !reset;
      wrDrop_o[w] = wrEn_i[w] && (state_q != ON);
    end
  end

  always_comb begin
    rdData_o = '0;
    for (int r = 0; r < NUM_RD_PORTS; r++) begin
      rdData_o[r] = (state_q == ON) ? mem_q[rdRow_i[r]] : '0;
    end
  end

  // Aborting a wake wins over reaching ON on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= OFF;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
`ifdef PART_CLEAR_ON_WAKE_EN
      clrRow_q <= '0;
`endif
    end else begin
      case (state_q)
        OFF: begin
          if (req_i) begin
            state_q  <= WAKE;
            cnt_q    <= CNT_LOAD;
`ifdef PART_CLEAR_ON_WAKE_EN
            clrRow_q <= '0;
`endif
          end
        end
        WAKE: begin
          if (!req_i) begin
            state_q <= OFF;
          end else begin
            if (cnt_q == '0) begin
              state_q <= ON;
              ready_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
`ifdef PART_CLEAR_ON_WAKE_EN
            if (clrEn) clrRow_q <= clrRow_q + 1'b1;
`endif
          end
        end
        ON: begin
          if (!req_i) begin
            state_q <= OFF;
            ready_q <= 1'b0;
          end
        end
        default: begin
          state_q <= OFF;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Later ports are applied last, so the highest-numbered port wins a same-row collision.
  always_ff @(posedge clk) begin
    if (!reset) begin
`ifdef PART_CLEAR_ON_WAKE_EN
      if (clrEn) mem_q[clrRow_q[RW-1:0]] <= '0;
`endif
      for (int w = 0; w < NUM_WR_PORTS; w++) begin
        if (wrCommit[w]) mem_q[wrRow_i[w]] <= wrData_i[w];
      end
    end
  end

endmodule

// File: rtl/lsq_ram_partitioned_gated.sv
// Partitioned LSQ data RAM: splits addresses into partition/row, fans out to lsq_ram_part copies.
// Optional build macro: PART_CLEAR_ON_WAKE_EN (clear-on-wake inside each partition).
module lsq_ram_partitioned_gated
  import lsq_ram_pkg::*;
#(
  parameter int NUM_RD_PORTS  = 2,
  parameter int NUM_WR_PORTS  = 2,
  parameter int DEPTH         = 32,
  parameter int INDEX         = 5,
  parameter int WIDTH         = 64,
  parameter int NUM_PARTS     = 4,
  parameter int NUM_PARTS_LOG = 2,
  parameter int WAKE_LAT      = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_RD_PORTS*INDEX-1:0]   addr_i,
  output logic [NUM_RD_PORTS*WIDTH-1:0]   data_o,
  input  logic [NUM_WR_PORTS*INDEX-1:0]   addrWr_i,
  input  logic [NUM_WR_PORTS*WIDTH-1:0]   dataWr_i,
  input  logic [NUM_WR_PORTS-1:0]         we_i,
  input  logic [NUM_PARTS-1:0]            partitionActive_i,
  output logic [NUM_PARTS-1:0]            partReady_o,
  output logic                            ramReady_o,
  output logic [NUM_WR_PORTS-1:0]         wrDropped_o
);

  localparam int ROWS     = DEPTH / NUM_PARTS;
  localparam int ROW_BITS = INDEX - NUM_PARTS_LOG;
  localparam int RW       = (ROW_BITS > 0) ? ROW_BITS : 1;
  localparam int PSW      = (NUM_PARTS_LOG > 0) ? NUM_PARTS_LOG : 1;

  logic [NUM_RD_PORTS-1:0][PSW-1:0]                 rdPart;
  logic [NUM_RD_PORTS-1:0][RW-1:0]                  rdRow;
  logic [NUM_WR_PORTS-1:0][PSW-1:0]                 wrPart;
  logic [NUM_WR_PORTS-1:0][RW-1:0]                  wrRow;
  logic [NUM_PARTS-1:0][NUM_RD_PORTS-1:0][WIDTH-1:0] partRd;
  logic [NUM_PARTS-1:0][NUM_WR_PORTS-1:0]           partDrop;
  part_state_t                                      partState [NUM_PARTS];

  always_comb begin
    rdPart = '0;
    rdRow  = '0;
    for (int r = 0; r < NUM_RD_PORTS; r++) begin
      rdPart[r] = PSW'(part_sel(32'(addr_i[r*INDEX +: INDEX]), INDEX, NUM_PARTS_LOG));
      rdRow[r]  = RW'(row_idx(32'(addr_i[r*INDEX +: INDEX]), INDEX, NUM_PARTS_LOG));
    end
  end

  always_comb begin
    wrPart = '0;
    wrRow  = '0;
    for (int w = 0; w < NUM_WR_PORTS; w++) begin
      wrPart[w] = PSW'(part_sel(32'(addrWr_i[w*INDEX +: INDEX]), INDEX, NUM_PARTS_LOG));
      wrRow[w]  = RW'(row_idx(32'(addrWr_i[w*INDEX +: INDEX]), INDEX, NUM_PARTS_LOG));
    end
  end

  for (genvar p = 0; p < NUM_PARTS; p++) begin : g_part
    logic [NUM_WR_PORTS-1:0] wrEn;

    always_comb begin
      wrEn = '0;
      for (int w = 0; w < NUM_WR_PORTS; w++) begin
        wrEn[w] = we_i[w] && (wrPart[w] == PSW'(p));
      end
    end

    lsq_ram_part #(
      .NUM_RD_PORTS (NUM_RD_PORTS),
      .NUM_WR_PORTS (NUM_WR_PORTS),
      .ROWS         (ROWS),
      .RW           (RW),
      .WIDTH        (WIDTH),
      .WAKE_LAT     (WAKE_LAT)
    ) u_part (
      .clk      (clk),
      .reset    (reset),
      .req_i    (partitionActive_i[p]),
      .rdRow_i  (rdRow),
      .rdData_o (partRd[p]),
      .wrEn_i   (wrEn),
      .wrRow_i  (wrRow),
      .wrData_i (dataWr_i),
      .wrDrop_o (partDrop[p]),
      .ready_o  (partReady_o[p]),
      .state_o  (partState[p])
    );
  end

  always_comb begin
    data_o = '0;
    for (int r = 0; r < NUM_RD_PORTS; r++) begin
      data_o[r*WIDTH +: WIDTH] = partRd[rdPart[r]][r];
    end
  end

  always_comb begin
    wrDropped_o = '0;
    for (int w = 0; w < NUM_WR_PORTS; w++) begin
      for (int p = 0; p < NUM_PARTS; p++) begin
        wrDropped_o[w] = wrDropped_o[w] | partDrop[p][w];
      end
    end
  end

  // Settled means every partition sits in the terminal state its request asks for.
  always_comb begin
    ramReady_o = 1'b1;
    for (int p = 0; p < NUM_PARTS; p++) begin
      if (partitionActive_i[p]) ramReady_o = ramReady_o & (partState[p] == ON);
      else                      ramReady_o = ramReady_o & (partState[p] == OFF);
    end
  end

endmodule

// File: doc/lsq_ram_partitioned_gated.md
Name: lsq_ram_partitioned_gated

Overview:
- Multi-port, partitioned LSQ data RAM with per-partition power sequencing.
- Address MSBs select a partition; LSBs index a row within it.
- Each partition has its own OFF/WAKE/ON state machine with a wake-latency counter.
- Aggregate ready handshake tells the LSQ when a partition reconfiguration has settled; sits under LSQ control beside the load/store queues.

Parameters:
- NUM_RD_PORTS, 2, number of asynchronous read ports.
- NUM_WR_PORTS, 2, number of synchronous write ports.
- DEPTH, 32, total rows; must be a multiple of NUM_PARTS.
- INDEX, 5, address width, log2(DEPTH).
- WIDTH, 64, data width.
- NUM_PARTS, 4, partition count, power of 2 (1 allowed).
- NUM_PARTS_LOG, 2, log2(NUM_PARTS); 0 when NUM_PARTS=1.
- WAKE_LAT, 3, cycles spent in WAKE, 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- addr_i  in  NUM_RD_PORTS*INDEX  read addresses.
- data_o  out  NUM_RD_PORTS*WIDTH  read data, combinational.
- addrWr_i  in  NUM_WR_PORTS*INDEX  write addresses.
- dataWr_i  in  NUM_WR_PORTS*WIDTH  write data.
- we_i  in  NUM_WR_PORTS  write enables.
- partitionActive_i  in  NUM_PARTS  requested power state per partition.
- partReady_o  out  NUM_PARTS  partition is ON.
- ramReady_o  out  1  every partition matches its request.
- wrDropped_o  out  NUM_WR_PORTS  write discarded this cycle, combinational.

Behaviour:
- Clocking/reset: one clock, clk; reset is synchronous, active-high.
- Address split: partSel = addr[INDEX-1:INDEX-NUM_PARTS_LOG], row = addr[INDEX-NUM_PARTS_LOG-1:0]. With NUM_PARTS=1, partSel=0 and row=addr.
- Partition FSM states and transitions (req = partitionActive_i[p], evaluated at each clk edge):
  - OFF -> WAKE when req=1; cnt loaded with WAKE_LAT-1.
  - WAKE -> decrement cnt; go to ON when cnt==0; go to OFF on the same edge if req=0 (abort takes priority).
  - ON -> OFF when req=0.
- Reset: all partitions go to OFF, cnt=0, partReady_o=0. ramReady_o is 1 only if partitionActive_i is all zero.
- Wake timing: request raised at edge N is seen at edge N+1 (OFF->WAKE); ON is reached at edge N+1+WAKE_LAT.
- partReady_o[p] = (state==ON), registered.
- ramReady_o = AND over p of (req ? state==ON : state==OFF); combinational from registered state and current request.
- Contents are not retained through OFF. After re-wake, rows read 0 when PART_CLEAR_ON_WAKE_EN is set; otherwise they are unspecified.
- Read: data_o[r] = row contents if the selected partition is ON, else 0. Reads are zero-latency. Write-to-read in the same cycle returns the old data (no bypass).
- Write: committed at the edge when we_i=1 and the selected partition is ON.
- Write to a partition not ON: discarded; wrDropped_o[w]=1 that cycle.
- Two ports writing the same address in one cycle: the highest-numbered port wins. The losing port does not assert wrDropped_o.
- Reset asserted mid-WAKE: partition goes to OFF; writes in that cycle are ignored.

Optional Feature:
- Macro: PART_CLEAR_ON_WAKE_EN.
- Defined:
  - WAKE zeroes the partition one row per cycle, row 0 upward, using a row counter.
  - WAKE lasts max(WAKE_LAT, DEPTH/NUM_PARTS) cycles.
  - Abort leaves the partition partially cleared; the next wake restarts from row 0.
  - User writes to a partition in WAKE are dropped as above.
- Undefined: no clear logic; WAKE lasts exactly WAKE_LAT cycles.

Decomposition:
- Shared package lsq_ram_pkg:
  - typedef part_state_t (OFF=2'b00, WAKE=2'b01, ON=2'b10).
  - Constant WAKE_CNT_W=4.
  - Function part_sel(addr) and function row_idx(addr).
- One sub-module lsq_ram_part: a single partition holding the storage array, the FSM, the counter, optional clear, and its own write-enable qualification. The top instantiates NUM_PARTS copies and muxes read data by partSel.

Test Plan:
- Reset with partitionActive_i=4'b0011 -> partReady_o=0 and ramReady_o=0; partReady_o=4'b0011 at cycle 1+WAKE_LAT=4, ramReady_o=1 the same cycle.
- Partitions ON; write port 0 addr 5'h09 data 64'hA5 -> next cycle read port 1 addr 5'h09 returns 64'hA5; wrDropped_o=0.
- Ports 0 and 1 both write addr 5'h02 with 64'h11 and 64'h22 -> read returns 64'h22; wrDropped_o=2'b00.
- partitionActive_i=4'b0001; write addr 5'h1F (partition 3) -> wrDropped_o[0]=1; read addr 5'h1F returns 0.
- Raise partitionActive_i[2], drop it after 1 cycle in WAKE -> state returns to OFF; partReady_o[2] never 1; ramReady_o=1 once back in OFF.
- With PART_CLEAR_ON_WAKE_EN: fill partition 1, cycle it OFF then ON -> after 8 WAKE cycles (DEPTH/NUM_PARTS=8 > WAKE_LAT=3) every row in addr 8..15 reads 0.
